// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver on the system clock, mid-bit sampling.
// Ports: clk, rst (sync, high), rx (async, idle high) -> data_out, rx_done, rx_busy, frame_err.
module uart_rx #(
  parameter int system_clk = 1000000,
  parameter int baudrate   = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       frame_err
);

  localparam int clks_per_bit = system_clk / baudrate;
  localparam int half_bit     = clks_per_bit / 2;

  localparam logic [15:0] BIT_END  = 16'(clks_per_bit - 1);
  localparam logic [15:0] HALF_END = 16'(half_bit - 1);

  if (clks_per_bit < 4) begin : g_chk
    $error("uart_rx: clks_per_bit must be >= 4");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t      state;
  logic        rx_m;
  logic        rx_s;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data_out  <= '0;
      rx_done   <= 1'b0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state   <= START;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_END) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              // too short to be a start bit
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          if (cnt == BIT_END) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        STOP: begin
          if (cnt == BIT_END) begin
            cnt <= '0;
            if (rx_s) begin
              data_out <= shift;
              rx_done  <= 1'b1;
              rx_busy  <= 1'b0;
              state    <= IDLE;
            end else begin
              // line held low: report once, then wait out the break
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        BREAK: begin
          cnt <= '0;
          if (rx_s) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven frames with a scoreboard of expected pulses.
// Hand sequences cover idle, glitch, reset mid-frame and recovery.
module tb_uart_rx;

  localparam int CPB  = 104;
  localparam int LAT  = 991;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data_out;
  logic       rx_done;
  logic       rx_busy;
  logic       frame_err;

  uart_rx dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (data_out),
    .rx_done   (rx_done),
    .rx_busy   (rx_busy),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic       err;
    logic [7:0] data;
    int         fall;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         hold;
    int         gap;
    logic       exp_err;
    logic [7:0] exp_dout;
  } vec_t;

  exp_t sb[$];
  exp_t e;
  vec_t tbl[5];

  int n_chk  = 0;
  int n_fail = 0;
  int n_done = 0;
  int n_err  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act,
                             input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // monitor: every pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (rx_done && frame_err)
      check("done_and_err", 32'd1, 32'd0);
    if (rx_done) n_done++;
    if (frame_err) n_err++;
    if (rx_done || frame_err) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {31'd0, frame_err}, {31'd0, rx_done});
        check("unexpected_pulse_any", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_kind_err", {31'd0, frame_err}, {31'd0, e.err});
        check("data_out", {24'd0, data_out}, {24'd0, e.data});
        check_range("latency", cyc - e.fall, LAT - 2, LAT + 2);
      end
    end
  end

  // caller is at a negedge; leaves rx at the stop-bit value
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input bit expect_out, input logic exp_err,
                            input logic [7:0] exp_dout, input int rst_bit);
    logic [9:0] bits;
    exp_t x;
    bits = {stop, d, 1'b0};
    if (expect_out) begin
      x.err  = exp_err;
      x.data = exp_dout;
      x.fall = cyc;
      sb.push_back(x);
    end
    for (int b = 0; b < 10; b++) begin
      rx = bits[b];
      for (int c = 0; c < CPB; c++) begin
        if (c == 52 && b > 0 && expect_out)
          check("busy_in_frame", {31'd0, rx_busy}, 32'd1);
        if (b == rst_bit && c == 50) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          rx  = 1'b1;
          return;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
    check("sb_drain", sb.size(), 32'd0);
  endtask

  int t0;

  initial begin
    tbl[0] = '{8'hA5, 1'b1, 0,   200, 1'b0, 8'hA5};
    tbl[1] = '{8'h00, 1'b1, 0,   0,   1'b0, 8'h00};
    tbl[2] = '{8'hFF, 1'b1, 0,   200, 1'b0, 8'hFF};
    tbl[3] = '{8'h3C, 1'b0, 300, 200, 1'b1, 8'hFF};
    tbl[4] = '{8'h11, 1'b1, 0,   200, 1'b0, 8'h11};

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_data_out", {24'd0, data_out}, 32'd0);
    check("rst_busy", {31'd0, rx_busy}, 32'd0);
    check("rst_done", {31'd0, rx_done}, 32'd0);
    check("rst_err", {31'd0, frame_err}, 32'd0);

    // idle line
    repeat (2000) @(negedge clk);
    check("idle_busy", {31'd0, rx_busy}, 32'd0);
    check("idle_data_out", {24'd0, data_out}, 32'd0);
    check("idle_done_cnt", n_done, 32'd0);

    // glitch shorter than half a bit
    rx = 1'b0;
    t0 = cyc;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    check("glitch_busy_hi", {31'd0, rx_busy}, 32'd1);
    for (int i = 0; i < 200 && rx_busy; i++) @(negedge clk);
    check_range("glitch_busy_len", cyc - t0 - 3, 50, 54);
    repeat (300) @(negedge clk);
    check("glitch_no_done", n_done, 32'd0);
    check("glitch_no_err", n_err, 32'd0);

    // table of frames
    for (int i = 0; i < 5; i++) begin
      send_frame(tbl[i].data, tbl[i].stop, 1'b1, tbl[i].exp_err,
                 tbl[i].exp_dout, -1);
      if (tbl[i].hold > 0) begin
        repeat (tbl[i].hold) @(negedge clk);
        check("break_busy", {31'd0, rx_busy}, 32'd1);
        check("break_data_held", {24'd0, data_out},
              {24'd0, tbl[i].exp_dout});
      end
      rx = 1'b1;
      repeat (tbl[i].gap) @(negedge clk);
    end
    drain();
    check("tbl_done_cnt", n_done, 32'd4);
    check("tbl_err_cnt", n_err, 32'd1);
    check("tbl_busy_idle", {31'd0, rx_busy}, 32'd0);

    // reset during data bit 4 of 0x5A
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 8'h00, 5);
    check("midrst_data_out", {24'd0, data_out}, 32'd0);
    check("midrst_busy", {31'd0, rx_busy}, 32'd0);
    repeat (1200) @(negedge clk);
    check("midrst_busy_late", {31'd0, rx_busy}, 32'd0);
    check("midrst_no_done", n_done, 32'd4);
    check("midrst_no_err", n_err, 32'd1);

    // recovery frame
    send_frame(8'hC3, 1'b1, 1'b1, 1'b0, 8'hC3, -1);
    rx = 1'b1;
    drain();
    check("final_data_out", {24'd0, data_out}, 32'hC3);
    check("final_done_cnt", n_done, 32'd5);
    check("final_err_cnt", n_err, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
